// File: rtl/mmio_uart_tx_pkg.sv
// Shared register offsets, STATUS bit positions, access-size codes and FSM states for the MMIO UART transmitter.
package mmio_uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 8;
  localparam int STAT_CNT_W  = 5;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: push ignored when full, pop ignored when empty.
// Read data is the head entry, available combinationally; count reaches DEPTH when full.
module mmio_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: stored bytes queue in a FIFO and leave 8N1 (8E1 with UART_TX_PARITY_EN) at BAUDDIV clocks per bit.
// Reads are combinational; TXDATA pushes into a full FIFO are dropped and set the sticky overflow flag.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8020_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] perip_addr,
  input  logic [31:0] perip_wdata,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  output logic [31:0] perip_rdata,
  output logic        perip_hit,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    off;
  logic          wr, push, pop, full, empty, load, bit_end;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] count;
  logic [15:0]   baud_q, baud_d, div_eff;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, bit_div_q, bit_div_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          unused_bits;

  assign unused_bits = ^{perip_addr[1:0], perip_wdata[31:16]};

  assign perip_hit = (perip_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = {perip_addr[3:2], 2'b00};
  assign wr        = perip_wen & perip_hit;
  assign push      = wr && (off == OFF_TXDATA);

  mmio_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (perip_wdata[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    status                                  = '0;
    status[STAT_BUSY]                       = tx_busy | ~empty;
    status[STAT_FULL]                       = full;
    status[STAT_EMPTY]                      = empty;
    status[STAT_OVF]                        = ovf_q;
    status[STAT_CNT_LO +: STAT_CNT_W]       = STAT_CNT_W'(count);
  end

  always_comb begin
    perip_rdata = '0;
    if (perip_hit) begin
      case (off)
        OFF_STATUS:  perip_rdata = status;
        OFF_BAUDDIV: perip_rdata = {16'h0, baud_q};
        default:     perip_rdata = '0;
      endcase
    end
  end

  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (push && full) ovf_d = 1'b1;
    if (wr && (off == OFF_STATUS) && perip_wdata[STAT_OVF]) ovf_d = 1'b0;
    if (wr && (off == OFF_BAUDDIV)) begin
      case (perip_mask)
        MASK_B:         baud_d[7:0] = perip_wdata[7:0];
        MASK_H, MASK_W: baud_d      = perip_wdata[15:0];
        default:        baud_d      = perip_wdata[15:0];
      endcase
    end
  end

  assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_end = (cnt_q == bit_div_q - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_div_q <= 16'd1;
      shreg_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_div_q <= bit_div_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_div_d = bit_div_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q != IDLE) cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    case (state_q)
      IDLE:  if (!empty) load = 1'b1;
      START: if (bit_end) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
      end
      DATA:  if (bit_end) begin
        shreg_d   = {1'b0, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = STOP;
`endif
      end
      PARITY: if (bit_end) state_d = STOP;
      // Chaining straight from STOP into START keeps back-to-back frames gapless.
      STOP:  if (bit_end) begin
        if (!empty) load = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop       = 1'b1;
      shreg_d   = fifo_rdata;
      bit_div_d = div_eff;
      cnt_d     = 16'd0;
      state_d   = START;
`ifdef UART_TX_PARITY_EN
      par_d     = ^fifo_rdata;
`endif
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx = par_q;
`endif
      default: uart_tx = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, plus a line monitor that checks each frame against a queue of expected bytes.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h8020_0000;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perip_addr = '0;
  logic [31:0] perip_wdata = '0;
  logic        perip_wen = 1'b0;
  logic [1:0]  perip_mask = MASK_W;
  logic [31:0] perip_rdata;
  logic        perip_hit;
  logic        uart_tx;
  logic        tx_busy;

  mmio_uart_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .perip_addr  (perip_addr),
    .perip_wdata (perip_wdata),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_rdata (perip_rdata),
    .perip_hit   (perip_hit),
    .uart_tx     (uart_tx),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         b2b;
  } frame_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic [31:0] exp_rd;
    bit          exp_hit;
  } vec_t;

  frame_t sb[$];
  vec_t   vt[17];
  int     vecs_applied = 0;
  int     miscompares  = 0;
  bit     mon_busy     = 1'b0;
  int     cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    perip_addr  = a;
    perip_wdata = d;
    perip_mask  = m;
    perip_wen   = 1'b1;
    @(posedge clk);
    #1;
    perip_wen   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    perip_addr = a;
    perip_wen  = 1'b0;
    #1;
    chk(name, perip_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int n, input bit b2b);
    frame_t f;
    f.data = d;
    f.n    = n;
    f.b2b  = b2b;
    sb.push_back(f);
    bus_wr(BASE + 32'h0, {24'hC0FFEE, d}, MASK_W);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((sb.size() != 0 || mon_busy || tx_busy) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_within_budget", (i < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Line monitor: on each start bit, pops the expected frame and checks every sampled cycle.
  initial begin : monitor
    logic        prev, act;
    logic [10:0] bits;
    frame_t      f;
    bit          ok, ab;
    int          bad_b, last_end;
    prev = 1'b1;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
        mon_busy = 1'b0;
        continue;
      end
      if (prev && !uart_tx) begin
        if (sb.size() == 0) begin
          vecs_applied++;
          miscompares++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
          prev = 1'b0;
          continue;
        end
        mon_busy = 1'b1;
        f = sb.pop_front();
        if (f.b2b) chk("b2b_start_cycle", cyc, last_end + 1);
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = f.data;
`ifdef UART_TX_PARITY_EN
        bits[9]    = ^f.data;
`endif
        ok = 1'b1; ab = 1'b0; bad_b = -1; act = 1'b0;
        for (int b = 0; b < NBITS && !ab; b++) begin
          for (int c = 0; c < f.n && !ab; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              if (!rst_n) ab = 1'b1;
            end
            if (!ab && ok && uart_tx !== bits[b]) begin
              ok = 1'b0; bad_b = b; act = uart_tx;
            end
          end
        end
        if (!ab) begin
          vecs_applied++;
          if (!ok) begin
            miscompares++;
            $display("FAIL frame_%h: bit slot %0d line=%b, required %b (N=%0d)",
                     f.data, bad_b, act, bits[bad_b], f.n);
          end
          last_end = cyc;
        end
        prev = 1'b1;
        mon_busy = 1'b0;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c, bad;
    vt[0]  = '{1'b0, BASE + 32'h4,  32'h0,         MASK_W, 32'h0000_0004, 1'b1};
    vt[1]  = '{1'b0, BASE + 32'h8,  32'h0,         MASK_W, 32'd434,       1'b1};
    vt[2]  = '{1'b0, 32'h0,         32'h0,         MASK_W, 32'h0,         1'b0};
    vt[3]  = '{1'b0, BASE + 32'h0,  32'h0,         MASK_W, 32'h0,         1'b1};
    vt[4]  = '{1'b0, BASE + 32'hC,  32'h0,         MASK_W, 32'h0,         1'b1};
    vt[5]  = '{1'b0, BASE + 32'h10, 32'h0,         MASK_W, 32'h0,         1'b0};
    vt[6]  = '{1'b1, BASE + 32'h8,  32'h0000_0100, MASK_W, 32'h0,         1'b1};
    vt[7]  = '{1'b0, BASE + 32'h8,  32'h0,         MASK_W, 32'h0000_0100, 1'b1};
    vt[8]  = '{1'b1, BASE + 32'h8,  32'hFFFF_FF12, MASK_B, 32'h0,         1'b1};
    vt[9]  = '{1'b0, BASE + 32'h8,  32'h0,         MASK_W, 32'h0000_0112, 1'b1};
    vt[10] = '{1'b1, BASE + 32'hA,  32'h1234_ABCD, MASK_H, 32'h0,         1'b1};
    vt[11] = '{1'b0, BASE + 32'hB,  32'h0,         MASK_W, 32'h0000_ABCD, 1'b1};
    vt[12] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, MASK_W, 32'h0,         1'b1};
    vt[13] = '{1'b0, BASE + 32'hC,  32'h0,         MASK_W, 32'h0,         1'b1};
    vt[14] = '{1'b1, BASE + 32'h4,  32'hFFFF_FFF7, MASK_W, 32'h0,         1'b1};
    vt[15] = '{1'b0, BASE + 32'h4,  32'h0,         MASK_W, 32'h0000_0004, 1'b1};
    vt[16] = '{1'b0, 32'h801F_FFFC, 32'h0,         MASK_W, 32'h0,         1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("reset_tx_busy", {31'h0, tx_busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      if (vt[i].wen) begin
        bus_wr(vt[i].addr, vt[i].wdata, vt[i].mask);
      end else begin
        perip_addr = vt[i].addr;
        perip_wen  = 1'b0;
        #1;
        chk($sformatf("vec%0d_rdata", i), perip_rdata, vt[i].exp_rd);
        chk($sformatf("vec%0d_hit", i), {31'h0, perip_hit}, {31'h0, vt[i].exp_hit});
        @(posedge clk);
        #1;
      end
    end

    // 0xA5 at N=4: one-edge pop latency and exact frame length
    bus_wr(BASE + 32'h8, 32'd4, MASK_W);
    begin
      frame_t f;
      f.data = 8'hA5; f.n = 4; f.b2b = 1'b0;
      sb.push_back(f);
    end
    perip_addr = BASE; perip_wdata = 32'h0000_00A5; perip_mask = MASK_B; perip_wen = 1'b1;
    @(posedge clk);
    #1;
    perip_wen = 1'b0;
    chk("latency_edge_k_idle", {31'h0, uart_tx}, 32'h1);
    @(posedge clk);
    #1;
    chk("latency_edge_k1_start", {31'h0, uart_tx}, 32'h0);
    c = 0;
    while (tx_busy && c < 500) begin
      c++;
      @(posedge clk);
      #1;
    end
    chk("frame_len_n4", c, NBITS * 4);
    wait_idle(500);

    // back-to-back frames at N=2
    bus_wr(BASE + 32'h8, 32'd2, MASK_W);
    send(8'h55, 2, 1'b0);
    send(8'h0F, 2, 1'b1);
    rd_chk("status_count1", BASE + 32'h4, 32'h0000_0101);
    repeat (23) @(posedge clk);
    #1;
    rd_chk("status_count0", BASE + 32'h4, 32'h0000_0005);
    wait_idle(500);
    rd_chk("status_after_b2b", BASE + 32'h4, 32'h0000_0004);

    // BAUDDIV rewritten mid-frame only affects the following frame
    bus_wr(BASE + 32'h8, 32'd3, MASK_W);
    send(8'h3C, 3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus_wr(BASE + 32'h8, 32'd5, MASK_H);
    send(8'hC3, 5, 1'b1);
    wait_idle(500);

    // BAUDDIV=0 behaves as one cycle per bit; then 0x07 at N=3
    bus_wr(BASE + 32'h8, 32'd0, MASK_W);
    send(8'h5A, 1, 1'b0);
    wait_idle(500);
    bus_wr(BASE + 32'h8, 32'd3, MASK_W);
    send(8'h07, 3, 1'b0);
    wait_idle(500);

    // fill to full, overflow on the next push, clear via STATUS bit3
    bus_wr(BASE + 32'h8, 32'd1000, MASK_W);
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1000, 1'b0);
    rd_chk("status_full", BASE + 32'h4, 32'h0000_0803);
    bus_wr(BASE + 32'h0, 32'h0000_00EE, MASK_B);
    rd_chk("status_overflow", BASE + 32'h4, 32'h0000_080B);
    bus_wr(BASE + 32'h4, 32'h0000_0008, MASK_W);
    rd_chk("status_ovf_cleared", BASE + 32'h4, 32'h0000_0803);
    do_reset();
    rd_chk("status_after_reset", BASE + 32'h4, 32'h0000_0004);
    rd_chk("bauddiv_after_reset", BASE + 32'h8, 32'd434);

    // asynchronous reset while a zero data bit is on the line
    bus_wr(BASE + 32'h8, 32'd8, MASK_W);
    send(8'hF0, 8, 1'b0);
    repeat (12) @(posedge clk);
    #3;
    chk("pre_reset_line_low", {31'h0, uart_tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_line_high", {31'h0, uart_tx}, 32'h1);
    chk("async_reset_not_busy", {31'h0, tx_busy}, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("status_after_mid_reset", BASE + 32'h4, 32'h0000_0004);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("no_residual_frame", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
    $finish;
  end

endmodule
